// File: rtl/tri_bus_pkg.sv
//------------------------------------------------------------------------------
// tri_bus_pkg
//
// Shared definitions for the tri-state bus arbiter slice.
//
// Contents:
//   arb_state_e     - controller state encoding (IDLE / OWN / TURN), 2 bits
//   N_REQ_DEF       - default number of requesters
//   TURNAROUND_DEF  - default idle gap between two owners, in cycles
//   MAX_HOLD_DEF    - default ownership limit used by the hold timeout
//   HOLD_W          - width of the hold counter
//   TURN_W          - width of the turnaround counter (TURNAROUND <= 7)
//   id_width()      - index width for a given requester count
//------------------------------------------------------------------------------
package tri_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no owner, arbitrating every cycle
        ST_OWN  = 2'd1,   // exactly one enable high
        ST_TURN = 2'd2    // all enables low, counting the gap
    } arb_state_e;

    localparam int N_REQ_DEF      = 4;
    localparam int TURNAROUND_DEF = 1;
    localparam int MAX_HOLD_DEF   = 8;

    localparam int HOLD_W = 8;
    localparam int TURN_W = 3;

    // Number of bits needed to hold an index 0..n-1 (at least 1).
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : tri_bus_pkg

// File: rtl/tri_bus_arbiter_rr_pick.sv
//------------------------------------------------------------------------------
// rr_pick
//
// Combinational round-robin picker. The request vector is rotated so that the
// position after the previous owner lands on bit 0, a fixed lowest-bit-first
// priority is applied, and the winning position is rotated back to an
// absolute index.
//
// Ports:
//   req       in   N_REQ  request vector
//   last      in   ID_W   index of the most recent owner
//   grant     out  N_REQ  one-hot winner (all zero when nothing is requested)
//   grant_id  out  ID_W   index of the winner (0 when found is low)
//   found     out  1      at least one request is pending
//------------------------------------------------------------------------------
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_id,
    output logic             found
);

    int               start;
    int               pick;
    logic [ID_W-1:0]  idx;
    logic [N_REQ-1:0] rot_req;

    // NOTE: every variable assigned in this block gets a default value first,
    // so no path through it can leave a value unassigned and infer a latch.
    always_comb begin
        start    = 0;
        pick     = 0;
        idx      = '0;
        rot_req  = '0;
        found    = 1'b0;
        grant    = '0;
        grant_id = '0;

        // Search starts one past the previous owner, wrapping at N_REQ.
        start = (int'(last) >= N_REQ - 1) ? 0 : int'(last) + 1;

        for (int i = 0; i < N_REQ; i++) begin
            idx        = ID_W'((i + start) % N_REQ);
            rot_req[i] = req[idx];
        end

        // Walking downwards lets the lowest set bit overwrite any higher one,
        // which gives first-set priority without an early exit.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                found = 1'b1;
                pick  = i;
            end
        end

        if (found) begin
            grant_id        = ID_W'((pick + start) % N_REQ);
            grant[grant_id] = 1'b1;
        end
    end

endmodule : rr_pick

// File: rtl/tri_bus_arbiter.sv
//------------------------------------------------------------------------------
// tri_bus_arbiter
//
// Round-robin owner sequencer for a shared tri-state net. It owns the
// per-source drive enables so that at most one source drives the net and a
// turnaround gap of TURNAROUND all-low cycles always separates two owners.
//
// Optional feature: define TRI_BUS_ARB_TIMEOUT_EN to enable the hold timeout.
// With it, an owner still requesting after MAX_HOLD cycles of ownership is
// forcibly released and `preempt` pulses for the first gap cycle. Without it,
// there is no hold counter and `preempt` is tied low.
//
// Parameters:
//   N_REQ       number of requesters (2..16)
//   TURNAROUND  idle cycles between owners (1..7)
//   MAX_HOLD    ownership limit in cycles (2..255), timeout build only
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   req        in   N_REQ  level request per source
//   oe         out  N_REQ  one-hot-or-zero drive enable per source
//   owner_vld  out  1      high while any enable is high
//   owner_id   out  ID_W   index of the current owner, 0 when none
//   preempt    out  1      one-cycle pulse on a forced release
//
// All outputs come straight from registers.
//------------------------------------------------------------------------------
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter int N_REQ      = N_REQ_DEF,
    parameter int TURNAROUND = TURNAROUND_DEF,
    parameter int MAX_HOLD   = MAX_HOLD_DEF,
    localparam int ID_W      = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] oe,
    output logic             owner_vld,
    output logic [ID_W-1:0]  owner_id,
    output logic             preempt
);

    // Elaboration-time parameter range checks.
    if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
        $error("tri_bus_arbiter: N_REQ out of range 2..16");
    end
    if (TURNAROUND < 1 || TURNAROUND > 7) begin : g_bad_turnaround
        $error("tri_bus_arbiter: TURNAROUND out of range 1..7");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("tri_bus_arbiter: MAX_HOLD out of range 2..255");
    end

    //--------------------------------------------------------------------------
    // State and output registers
    //--------------------------------------------------------------------------
    arb_state_e       state_q,     state_d;
    logic [N_REQ-1:0] oe_q,        oe_d;
    logic             vld_q,       vld_d;
    logic [ID_W-1:0]  id_q,        id_d;
    logic [ID_W-1:0]  last_q,      last_d;
    logic [TURN_W-1:0] turn_cnt_q, turn_cnt_d;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              preempt_q,  preempt_d;
    logic              hold_hit;
`endif

    //--------------------------------------------------------------------------
    // Round-robin picker
    //--------------------------------------------------------------------------
    logic [N_REQ-1:0] pick_grant;
    logic [ID_W-1:0]  pick_id;
    logic             pick_found;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .req      (req),
        .last     (last_q),
        .grant    (pick_grant),
        .grant_id (pick_id),
        .found    (pick_found)
    );

    // The current owner still wants the bus. Only the owner's bit matters;
    // other requesters are ignored while the bus is owned.
    logic owner_req;
    assign owner_req = |(req & oe_q);

`ifdef TRI_BUS_ARB_TIMEOUT_EN
    // Hold count starts at 0 on the grant edge, so reaching MAX_HOLD-1 means
    // MAX_HOLD cycles of ownership will have elapsed at the next edge.
    assign hold_hit = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));
`endif

    //--------------------------------------------------------------------------
    // Next-state logic
    //--------------------------------------------------------------------------
    logic arb_en;
    logic release_bus;

    always_comb begin
        state_d     = state_q;
        oe_d        = oe_q;
        vld_d       = vld_q;
        id_d        = id_q;
        last_d      = last_q;
        turn_cnt_d  = turn_cnt_q;
        arb_en      = 1'b0;
        release_bus = 1'b0;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
        hold_cnt_d  = hold_cnt_q;
        preempt_d   = 1'b0;
`endif

        unique case (state_q)
            ST_IDLE: arb_en = 1'b1;

            ST_OWN: begin
                // A voluntary drop takes precedence over the timeout, so a
                // drop on the expiry edge is a normal release.
                if (!owner_req) begin
                    release_bus = 1'b1;
                end
`ifdef TRI_BUS_ARB_TIMEOUT_EN
                else if (hold_hit) begin
                    release_bus = 1'b1;
                    preempt_d   = 1'b1;
                end else begin
                    hold_cnt_d  = hold_cnt_q + 1'b1;
                end
`endif
            end

            ST_TURN: begin
                if (turn_cnt_q == '0) begin
                    arb_en = 1'b1;
                end else begin
                    turn_cnt_d = turn_cnt_q - 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (release_bus) begin
            state_d    = ST_TURN;
            oe_d       = '0;
            vld_d      = 1'b0;
            id_d       = '0;
            turn_cnt_d = TURN_W'(TURNAROUND - 1);
        end

        // Arbitration: a winner goes straight to OWN; `last` moves to the
        // winner so a preempted source that keeps requesting ends up behind
        // everyone else.
        if (arb_en) begin
            if (pick_found) begin
                state_d    = ST_OWN;
                oe_d       = pick_grant;
                vld_d      = 1'b1;
                id_d       = pick_id;
                last_d     = pick_id;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
                hold_cnt_d = '0;
`endif
            end else begin
                state_d    = ST_IDLE;
                oe_d       = '0;
                vld_d      = 1'b0;
                id_d       = '0;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // Reset drops the enable immediately, even mid-ownership; there
            // is no turnaround on the way into reset.
            state_q    <= ST_IDLE;
            oe_q       <= '0;
            vld_q      <= 1'b0;
            id_q       <= '0;
            last_q     <= ID_W'(N_REQ - 1);
            turn_cnt_q <= '0;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= '0;
            preempt_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            oe_q       <= oe_d;
            vld_q      <= vld_d;
            id_q       <= id_d;
            last_q     <= last_d;
            turn_cnt_q <= turn_cnt_d;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
            hold_cnt_q <= hold_cnt_d;
            preempt_q  <= preempt_d;
`endif
        end
    end

    assign oe        = oe_q;
    assign owner_vld = vld_q;
    assign owner_id  = id_q;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
    assign preempt   = preempt_q;
`else
    assign preempt   = 1'b0;
`endif

endmodule : tri_bus_arbiter

// File: tb/tb_tri_bus_arbiter.sv
//------------------------------------------------------------------------------
// tb_tri_bus_arbiter
//
// Self-checking bench for tri_bus_arbiter with N_REQ=4, TURNAROUND=1,
// MAX_HOLD=4. A reference model tracks the current owner, the remaining gap
// and cycles owned as plain integers and is stepped once per rising edge.
// The timeout scenarios run only when TRI_BUS_ARB_TIMEOUT_EN is defined.
//------------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    localparam int N  = 4;
    localparam int TA = 1;
    localparam int MH = 4;
`ifdef TRI_BUS_ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] oe;
    logic         owner_vld;
    logic [1:0]   owner_id;
    logic         preempt;

    tri_bus_arbiter #(
        .N_REQ      (N),
        .TURNAROUND (TA),
        .MAX_HOLD   (MH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .oe        (oe),
        .owner_vld (owner_vld),
        .owner_id  (owner_id),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    wire [7:0] dut_vec = {oe, owner_vld, owner_id, preempt};

    //--------------------------------------------------------------------------
    // Reference model
    //--------------------------------------------------------------------------
    int m_owner   = -1;   // -1: nobody owns the bus
    int m_gap     = 0;    // all-low cycles still to go before arbitration
    int m_last    = N - 1;
    int m_held    = 0;    // cycles of ownership so far, 1 on the grant edge
    bit m_preempt = 1'b0;

    task automatic model_edge(input logic [N-1:0] r, input logic rn);
        m_preempt = 1'b0;
        if (!rn) begin
            m_owner = -1;
            m_gap   = 0;
            m_last  = N - 1;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner]) begin
                m_owner = -1;
                m_gap   = TA;
            end else if (TIMEOUT_ON && m_held >= MH) begin
                m_owner   = -1;
                m_gap     = TA;
                m_preempt = 1'b1;
            end else begin
                m_held++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            for (int k = 1; k <= N; k++) begin
                int cand;
                cand = (m_last + k) % N;
                if (m_owner < 0 && r[cand]) begin
                    m_owner = cand;
                    m_last  = cand;
                    m_held  = 1;
                end
            end
        end
    endtask

    function automatic logic [7:0] exp_vec();
        logic [N-1:0] o;
        logic [1:0]   id;
        o  = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        id = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
        return {o, (m_owner >= 0), id, m_preempt};
    endfunction

    // Drive inputs away from the edge, step DUT and model, sample #1 later.
    task automatic cycle(input logic [N-1:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        @(posedge clk);
        model_edge(r, rn);
        #1;
    endtask

    //--------------------------------------------------------------------------
    // Scenarios
    //--------------------------------------------------------------------------
    task automatic test_reset();
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b0);
        checks++;
        if (dut_vec !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", dut_vec, 8'h00);
        end
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model: got %b expected %b", dut_vec, exp_vec());
        end
        cycle(4'b1111, 1'b1);
        checks++;
        if (oe !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_grant: oe got %b expected 0001", oe);
        end
    endtask

    task automatic test_single();
        cycle(4'b0000, 1'b0);
        for (int e = 1; e <= 5; e++) begin
            cycle((e <= 3) ? 4'b0100 : 4'b0000, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL single_e%0d: got %b expected %b", e, dut_vec, exp_vec());
            end
            if (e == 1) begin
                checks++;
                if (oe !== 4'b0100 || owner_id !== 2'd2) begin
                    errors++;
                    $display("FAIL single_grant: oe %b id %0d expected 0100 id 2", oe, owner_id);
                end
            end
            if (e == 4) begin
                checks++;
                if (oe !== 4'b0000) begin
                    errors++;
                    $display("FAIL single_release: oe got %b expected 0000", oe);
                end
            end
        end
    endtask

    task automatic test_rotation();
        int   owners[$];
        int   gaps[$];
        int   gap_run;
        logic prev_vld;
        int   exp_own[4] = '{0, 2, 0, 2};
        logic [N-1:0] r;
        gap_run  = 0;
        prev_vld = 1'b0;
        cycle(4'b0000, 1'b0);
        for (int c = 0; c < 60 && owners.size() < 5; c++) begin
            r = 4'b0101;
            if (m_owner >= 0 && m_held >= 2) r[m_owner] = 1'b0;
            cycle(r, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rotation_c%0d: got %b expected %b", c, dut_vec, exp_vec());
            end
            if (owner_vld && !prev_vld) begin
                if (owners.size() > 0) gaps.push_back(gap_run);
                owners.push_back(int'(owner_id));
                gap_run = 0;
            end else if (!owner_vld) begin
                gap_run++;
            end
            prev_vld = owner_vld;
        end
        checks++;
        if (owners.size() < 4) begin
            errors++;
            $display("FAIL rotation_count: got %0d owners expected at least 4", owners.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (owners[i] != exp_own[i]) begin
                    errors++;
                    $display("FAIL rotation_owner%0d: got %0d expected %0d", i, owners[i], exp_own[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (gaps[i] != 1) begin
                    errors++;
                    $display("FAIL rotation_gap%0d: got %0d expected 1", i, gaps[i]);
                end
            end
        end
    endtask

`ifdef TRI_BUS_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int   run_id[$];
        int   run_len[$];
        int   cur_id;
        int   cur_len;
        int   n_pre;
        logic prev_vld;
        int   exp_id[5] = '{0, 1, 2, 3, 0};
        cur_id   = 0;
        cur_len  = 0;
        n_pre    = 0;
        prev_vld = 1'b0;
        cycle(4'b0000, 1'b0);
        for (int c = 0; c < 26; c++) begin
            cycle(4'b1111, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL timeout_c%0d: got %b expected %b", c, dut_vec, exp_vec());
            end
            checks++;
            if ($countones(oe) > 1) begin
                errors++;
                $display("FAIL timeout_onehot: oe got %b expected at most one bit", oe);
            end
            if (preempt) n_pre++;
            if (owner_vld) begin
                if (!prev_vld) begin
                    cur_id  = int'(owner_id);
                    cur_len = 1;
                end else begin
                    cur_len++;
                end
            end else if (prev_vld) begin
                run_id.push_back(cur_id);
                run_len.push_back(cur_len);
            end
            prev_vld = owner_vld;
        end
        checks++;
        if (run_id.size() < 5) begin
            errors++;
            $display("FAIL timeout_runs: got %0d runs expected 5", run_id.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (run_id[i] != exp_id[i] || run_len[i] != MH) begin
                    errors++;
                    $display("FAIL timeout_run%0d: owner %0d len %0d expected owner %0d len %0d",
                             i, run_id[i], run_len[i], exp_id[i], MH);
                end
            end
        end
        checks++;
        if (n_pre != 5) begin
            errors++;
            $display("FAIL timeout_preempts: got %0d expected 5", n_pre);
        end
    endtask

    task automatic test_tie();
        cycle(4'b0000, 1'b0);
        for (int e = 1; e <= 6; e++) begin
            cycle((e == 5) ? 4'b0000 : 4'b0010, 1'b1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL tie_e%0d: got %b expected %b", e, dut_vec, exp_vec());
            end
            if (e == 5) begin
                checks++;
                if (preempt !== 1'b0 || oe !== 4'b0000) begin
                    errors++;
                    $display("FAIL tie_release: preempt %b oe %b expected 0 0000", preempt, oe);
                end
            end
            if (e == 6) begin
                checks++;
                if (oe !== 4'b0010) begin
                    errors++;
                    $display("FAIL tie_regrant: oe got %b expected 0010", oe);
                end
            end
        end
    endtask
`endif

    task automatic test_mid_reset();
        cycle(4'b0000, 1'b0);
        cycle(4'b0100, 1'b1);
        cycle(4'b0100, 1'b1);
        checks++;
        if (oe !== 4'b0100) begin
            errors++;
            $display("FAIL midrst_owner: oe got %b expected 0100", oe);
        end
        cycle(4'b0100, 1'b0);
        checks++;
        if (dut_vec !== exp_vec() || oe !== 4'b0000) begin
            errors++;
            $display("FAIL midrst_drop: got %b expected %b", dut_vec, exp_vec());
        end
        cycle(4'b0110, 1'b1);
        checks++;
        if (oe !== 4'b0010 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL midrst_regrant: oe got %b expected 0010", oe);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] r;
        logic         rn;
        logic [N-1:0] prev_oe;
        prev_oe = '0;
        cycle(4'b0000, 1'b0);
        for (int c = 0; c < 500; c++) begin
            r  = N'($urandom);
            rn = ($urandom_range(0, 59) != 0);
            cycle(r, rn);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random_c%0d: got %b expected %b", c, dut_vec, exp_vec());
            end
            checks++;
            if ($countones(oe) > 1 || (prev_oe != '0 && oe != '0 && oe != prev_oe)) begin
                errors++;
                $display("FAIL random_overlap_c%0d: oe %b after %b", c, oe, prev_oe);
            end
            prev_oe = oe;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = '0;
        #1;
        test_reset();
        test_single();
        test_rotation();
`ifdef TRI_BUS_ARB_TIMEOUT_EN
        test_timeout();
        test_tie();
`endif
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_tri_bus_arbiter
